// File: rtl/cover_toggle_collector_if.sv
// ---------------------------------------------------------------------------
// cover_toggle_collector_if
// Ready/valid report stream carrying absolute cover indices from the toggle
// collector to its consumer (coverage uploader, cover harness, trace sink).
//
// Signals:
//   report_valid  collector -> consumer  a pending cover index is presented
//   report_ready  consumer  -> collector consumer accepts report_index
//   report_index  collector -> consumer  absolute cover index, IDX_W bits
//
// Modports:
//   master  the collector side (drives valid/index, samples ready)
//   slave   the consumer side (samples valid/index, drives ready)
// ---------------------------------------------------------------------------
interface cover_toggle_collector_if #(
  parameter int IDX_W = 64
) ();

  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_index;

  modport master (
    output report_valid,
    output report_index,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_index,
    output report_ready
  );

endinterface

// File: rtl/cover_toggle_collector.sv
// ---------------------------------------------------------------------------
// cover_toggle_collector
// Samples a WIDTH-bit vector of toggle events every gbl_clk edge, keeps a
// sticky map of bits ever hit, and serialises new hits into a ready/valid
// stream of absolute cover indices (lowest pending bit first).
//
// Parameters:
//   WIDTH        number of toggle points in this instance (1..1024)
//   COVER_INDEX  absolute cover index of bit 0
//   COVER_TOTAL  global cover-point count (COVER_INDEX+WIDTH must fit)
//   MODE         0 = first hit only, 1 = every sampled hit is re-queued
//   IDX_W        width of report_index
//
// Ports:
//   gbl_clk      clock
//   reset        synchronous, active-low; clears all state
//   valid        toggle events sampled at every edge
//   clear        synchronous re-arm, active-high; clears all state
//   report       report stream (master side of cover_toggle_collector_if)
//   hit_map      sticky set of bits hit since reset/clear
//   hit_count    number of set bits in hit_map
//   all_covered  every bit of hit_map is set
//   drop_count   saturating count of hits lost to an already pending bit
// ---------------------------------------------------------------------------
module cover_toggle_collector #(
  parameter int WIDTH       = 27,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 28338,
  parameter int MODE        = 0,
  parameter int IDX_W       = 64
) (
  input  logic                         gbl_clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  cover_toggle_collector_if.master     report,
  output logic [WIDTH-1:0]             hit_map,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_covered,
  output logic [15:0]                  drop_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH %0d outside 1..1024", WIDTH);
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("cover_toggle_collector: MODE must be 0 or 1");
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] fresh;
  logic [WIDTH-1:0] new_bits;
  logic [WIDTH-1:0] ack_mask;
  logic [WIDTH-1:0] pending_next;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;
  logic [IDX_W-1:0] low_pos;

  // Next-state terms. The acknowledged bit is the isolated lowest set bit
  // of pending; OR-ing new hits after removing it lets a simultaneous
  // re-hit keep the bit pending without being counted as a drop.
  always_comb begin
    fresh        = valid & ~hit_map;
    new_bits     = (MODE == 0) ? fresh : valid;
    ack_mask     = '0;
    if (report.report_valid && report.report_ready) begin
      ack_mask = pending & (~pending + WIDTH'(1));
    end
    pending_next = (pending & ~ack_mask) | new_bits;
    drop_sum     = '0;
    drop_next    = '0;
    if (MODE == 1) begin
      drop_sum  = {1'b0, drop_count} + 17'(popcount(valid & pending & ~ack_mask));
      drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Lowest pending position; scanning downward lets the lowest set bit win.
  always_comb begin
    low_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_pos = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset || clear) begin
      hit_map    <= '0;
      pending    <= '0;
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      hit_map    <= hit_map | valid;
      pending    <= pending_next;
      hit_count  <= hit_count + popcount(fresh);
      drop_count <= drop_next;
    end
  end

  assign report.report_valid = |pending;
  assign report.report_index = IDX_W'(COVER_INDEX) + low_pos;
  assign all_covered         = (hit_count == CNT_W'(WIDTH));

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Synthesizable, parametrised toggle-coverage collector. It samples a WIDTH-bit vector of toggle events and records first hits in a sticky map. New hits are serialised into a ready/valid stream of absolute cover indices, lowest bit first, for the on-chip coverage uploader, formal cover harness or FPGA trace sink. It replaces per-bit simulation-only reporting with a buffered, backpressure-aware report path, and adds distinct-hit counting, an all-covered flag, a re-arm clear and an every-hit mode.

## Interface
- WIDTH, 27: number of toggle points handled by this instance; legal range 1..1024.
- COVER_INDEX, 0: absolute index of bit 0; bit i reports COVER_INDEX+i.
- COVER_TOTAL, 28338: global cover-point count; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL.
- MODE, 0: 0 = first-hit only (sticky); 1 = every-hit (each sampled event is re-queued).
- IDX_W, 64: width of report_index.
- gbl_clk  in  1  clock.
- reset  in  1  synchronous, active-low; reset==0 at a gbl_clk edge resets all state.
- valid  in  WIDTH  toggle events, sampled at every gbl_clk edge while out of reset.
- clear  in  1  synchronous re-arm, active-high.
- report_ready  in  1  consumer accepts report_index this cycle.
- report_valid  out  1  a pending cover index is presented.
- report_index  out  IDX_W  COVER_INDEX + position of the lowest pending bit; zero-extended.
- hit_map  out  WIDTH  sticky set of bits ever hit since reset or clear.
- hit_count  out  clog2(WIDTH+1)  number of set bits in hit_map.
- all_covered  out  1  hit_map is all ones.
- drop_count  out  16  saturating count of hits lost because the bit was already pending (MODE 1 only).

## Operation
- State registers: hit_map[WIDTH], pending[WIDTH], hit_count, drop_count.
- Per edge, when reset==1 and clear==0:
  - new = MODE0 ? valid & ~hit_map : valid.
  - hit_map |= valid.
  - hit_count += popcount(valid & ~hit_map). This is exact and never exceeds WIDTH.
  - pending_next = (pending & ~ack_mask) | new. ack_mask is the one-hot lowest set bit of pending when report_valid && report_ready, else 0.
  - MODE1: drop_count += popcount(valid & pending & ~ack_mask), saturating at 16'hFFFF. In MODE0, drop_count stays 0.
- Simultaneous ack and re-hit of the same bit (MODE1): the set wins, the bit stays pending and no drop is counted.
- Outputs:
  - report_valid = |pending.
  - report_index = COVER_INDEX + priority_encode_lowest(pending). This is a combinational function of registered pending.
  - report_index is held stable while report_valid && !report_ready, unless a lower bit becomes pending. The consumer must treat each accepted index independently.
- all_covered = (hit_count == WIDTH).
- clear==1 (with reset==1): hit_map, pending, hit_count and drop_count go to 0. valid in that cycle is ignored, and any handshake in that cycle is discarded.
- reset==0: identical to clear. reset has priority over everything.
- Reset values: report_valid=0, report_index=COVER_INDEX, hit_map=0, hit_count=0, all_covered=0, drop_count=0.

## Timing
- Latency: a valid bit sampled at edge N appears on report_valid/report_index after edge N (visible in cycle N+1).
- Throughput: one report per cycle when report_ready is held 1.
- Drain: k pending bits drain in k ready cycles, in ascending bit order.
- hit_map, hit_count and all_covered update at the same edge as pending.
- No combinational path from valid or report_ready to any output.
- report_ready is ignored when report_valid==0.
- Reset or clear asserted mid-drain: pending is lost, and report_valid=0 from the next cycle.

## Test plan
- Reset: hold reset=0 for 2 edges with valid=all ones -> hit_map=0, report_valid=0, hit_count=0 after release.
- Burst drain (MODE0, COVER_INDEX=100, WIDTH=27): valid=27'h0000_0A1 for 1 cycle, report_ready=1 -> reports 100, 105, 107 on consecutive cycles, then report_valid=0; hit_count=3.
- Backpressure and dedup (MODE0): valid bit 3 for 5 cycles, report_ready=0 for 4 cycles then 1 -> report_index=COVER_INDEX+3 held stable, exactly one accept, hit_count=1, drop_count=0.
- Full coverage: drive each bit once in a random order -> hit_count=27, all_covered=1, and exactly 27 distinct indices COVER_INDEX..COVER_INDEX+26 are reported.
- MODE1 drops: bit 0 high for 10 cycles, report_ready=0 -> one pending report, drop_count=9. Then report_ready=1 with bit 0 still high -> a report every cycle and drop_count stays 9.
- Clear mid-drain: 5 bits pending, clear=1 after the 2nd accept -> next cycle report_valid=0, hit_map=0, hit_count=0. A re-hit of an already reported bit is reported again.
